// File: rtl/iobuf_loopback_checker_pkg.sv
// Shared types and the fixed 4-step pad drive/check table for the IOBUF loopback checker.
package iobuf_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int NUM_STEPS = 4;
    localparam int STEP_W    = $clog2(NUM_STEPS);

    // One bit per step, bit n = step n. Step 2 floats the pad so it is never compared.
    localparam logic [NUM_STEPS-1:0] STEP_T   = 4'b0100;
    localparam logic [NUM_STEPS-1:0] STEP_I   = 4'b0110;
    localparam logic [NUM_STEPS-1:0] STEP_EXP = 4'b0010;
    localparam logic [NUM_STEPS-1:0] STEP_CMP = 4'b1011;

    function automatic logic step_miss(input logic [STEP_W-1:0] step, input logic obs);
        return STEP_CMP[step] && (obs != STEP_EXP[step]);
    endfunction

endpackage

// File: rtl/iobuf_loopback_checker_if.sv
// Pad-side bundle between the checker (master) and the IOBUF (slave).
interface iobuf_loopback_checker_if;
    logic io_i;
    logic io_t;
    logic io_o;

    modport master (output io_i, output io_t, input io_o);
    modport slave  (input io_i, input io_t, output io_o);
endinterface

// File: rtl/iobuf_loopback_checker_sync.sv
// N-flop single-bit synchroniser for inputs asynchronous to clk; clears to 0 on reset.
module iobuf_chk_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/iobuf_loopback_checker.sv
// Tri-state pad self-test: steps the IOBUF through a 4-step T/I pattern and counts readback mismatches.
// Optional IOBUF_CHK_EXT_LOOP_EN adds ext_in, a second jumpered pad checked against the same pattern.
module iobuf_loopback_checker
    import iobuf_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int LOOPS         = 4,
    parameter int ERR_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
`ifdef IOBUF_CHK_EXT_LOOP_EN
    input  logic                      ext_in,
`endif
    iobuf_loopback_checker_if.master  pad,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_cnt
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = $clog2(LOOPS + 1);

    if (SETTLE_CYCLES < SYNC_STAGES + 2 || SYNC_STAGES < 2 || LOOPS < 1) begin : g_bad_cfg
        $error("iobuf_loopback_checker: need SYNC_STAGES>=2, SETTLE_CYCLES>=SYNC_STAGES+2, LOOPS>=1");
    end

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [LW-1:0]       loop_q;
    logic [TW-1:0]       timer_q;
    logic                io_t_q, io_i_q, busy_q, done_q, pass_q;
    logic [ERR_W-1:0]    err_q;

    logic                io_sync;
    logic                miss_io, miss_ext;
    logic [STEP_W-1:0]   step_nxt;
    logic [ERR_W:0]      err_sum;
    logic [ERR_W-1:0]    err_d;
    logic                last_step;

    iobuf_chk_sync #(.N(SYNC_STAGES)) u_sync_io (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pad.io_o),
        .q_o   (io_sync)
    );

`ifdef IOBUF_CHK_EXT_LOOP_EN
    logic ext_sync;

    iobuf_chk_sync #(.N(SYNC_STAGES)) u_sync_ext (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ext_in),
        .q_o   (ext_sync)
    );

    assign miss_ext = step_miss(step_q, ext_sync);
`else
    assign miss_ext = 1'b0;
`endif

    assign miss_io   = step_miss(step_q, io_sync);
    assign step_nxt  = step_q + 1'b1;
    assign last_step = (step_q == STEP_W'(NUM_STEPS - 1)) && (loop_q == LW'(LOOPS - 1));

    // One extra headroom bit detects overflow; the counter then sticks at all-ones.
    assign err_sum = {1'b0, err_q} + (ERR_W + 1)'(miss_io) + (ERR_W + 1)'(miss_ext);
    assign err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            loop_q  <= '0;
            timer_q <= '0;
            io_t_q  <= 1'b1;
            io_i_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_DRIVE;
                        step_q  <= '0;
                        loop_q  <= '0;
                        timer_q <= '0;
                        io_t_q  <= STEP_T[0];
                        io_i_q  <= STEP_I[0];
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
                        state_q <= ST_SAMPLE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    err_q <= err_d;
                    if (last_step) begin
                        state_q <= ST_DONE;
                        io_t_q  <= 1'b1;
                        io_i_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        state_q <= ST_DRIVE;
                        step_q  <= step_nxt;
                        io_t_q  <= STEP_T[step_nxt];
                        io_i_q  <= STEP_I[step_nxt];
                        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                            loop_q <= loop_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pad.io_t = io_t_q;
    assign pad.io_i = io_i_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_iobuf_loopback_checker.sv
// Directed bench for iobuf_loopback_checker (SETTLE_CYCLES=8, LOOPS=4); second instance has ERR_W=2.
module tb_iobuf_loopback_checker;

    localparam int SETTLE  = 8;
    localparam int LOOPS   = 4;
    localparam int RUN_LEN = 4 * LOOPS * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] pad_mode;    // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
    logic       rnd_bit = 1'b0;

    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic       busy2, done2, pass2;
    logic [1:0] err_cnt2;

    int checks   = 0;
    int failures = 0;

    iobuf_loopback_checker_if pif ();
    iobuf_loopback_checker_if pif2 ();

    always #5 clk = ~clk;
    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    assign pif.io_o  = (pad_mode == 2'd1) ? 1'b0 :
                       (pad_mode == 2'd2) ? 1'b1 :
                       (pif.io_t ? rnd_bit : pif.io_i);
    assign pif2.io_o = 1'b1;

`ifdef IOBUF_CHK_EXT_LOOP_EN
    logic ext_stuck0;
    logic ext_sig;
    assign ext_sig = ext_stuck0 ? 1'b0 : (pif.io_t ? rnd_bit : pif.io_i);
`endif

    iobuf_loopback_checker #(.SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2), .LOOPS(LOOPS), .ERR_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef IOBUF_CHK_EXT_LOOP_EN
        .ext_in  (ext_sig),
`endif
        .pad     (pif.master),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
    );

    iobuf_loopback_checker #(.SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2), .LOOPS(LOOPS), .ERR_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef IOBUF_CHK_EXT_LOOP_EN
        .ext_in  (1'b1),
`endif
        .pad     (pif2.master),
        .busy    (busy2),
        .done    (done2),
        .pass    (pass2),
        .err_cnt (err_cnt2)
    );

    // Returns with start sampled at edge k; caller is 1 time unit after edge k.
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Caller sits at the negedge after edge k; j = edge offset at which done is first seen.
    task automatic wait_done(output int j);
        j = 0;
        while (!done && j < 300) begin
            @(posedge clk); j++; @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (pif.io_t !== 1'b1 || pif.io_i !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || err_cnt !== 8'd0 || pif2.io_t !== 1'b1) begin
            failures++;
            $display("FAIL reset: io_t=%b io_i=%b busy=%b done=%b pass=%b err=%0d t2=%b, required 1 0 0 0 0 0 1",
                     pif.io_t, pif.io_i, busy, done, pass, err_cnt, pif2.io_t);
        end
        $display("reset: io_t=%b io_i=%b busy=%b done=%b err=%0d", pif.io_t, pif.io_i, busy, done, err_cnt);
    endtask

    task automatic test_ideal();
        int step, exp_t, exp_i, bad;
        pad_mode = 2'd0;
        pulse_start();
        bad = 0;
        for (int j = 0; j < RUN_LEN; j++) begin
            @(negedge clk);
            step  = (j / (SETTLE + 1)) % 4;
            exp_t = (step == 2) ? 1 : 0;
            exp_i = (step == 1 || step == 2) ? 1 : 0;
            checks++;
            if (pif.io_t !== 1'(exp_t) || pif.io_i !== 1'(exp_i) || busy !== 1'b1 || done !== 1'b0) begin
                failures++; bad++;
                if (bad < 5)
                    $display("FAIL ideal_pattern cyc=%0d: io_t=%b io_i=%b busy=%b done=%b, required %0d %0d 1 0",
                             j, pif.io_t, pif.io_i, busy, done, exp_t, exp_i);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_cnt !== 8'd0 ||
            pif.io_t !== 1'b1 || pif.io_i !== 1'b0) begin
            failures++;
            $display("FAIL ideal_done: done=%b busy=%b pass=%b err=%0d io_t=%b io_i=%b, required 1 0 1 0 1 0",
                     done, busy, pass, err_cnt, pif.io_t, pif.io_i);
        end
        $display("ideal: done at edge k+%0d pass=%b err=%0d", RUN_LEN, pass, err_cnt);
    endtask

    task automatic run_stuck(input logic [1:0] mode, input logic [7:0] exp_err, input string name);
        int j;
        pad_mode = mode;
        pulse_start();
        @(negedge clk);
        wait_done(j);
        checks++;
        if (j != RUN_LEN || err_cnt !== exp_err || pass !== (exp_err == 8'd0)) begin
            failures++;
            $display("FAIL %s: done_at=%0d err=%0d pass=%b, required %0d %0d %b",
                     name, j, err_cnt, pass, RUN_LEN, exp_err, (exp_err == 8'd0));
        end
        $display("%s: done_at=%0d err=%0d pass=%b", name, j, err_cnt, pass);
    endtask

    task automatic test_stuck();
        run_stuck(2'd1, 8'd4, "stuck0");
        run_stuck(2'd2, 8'd8, "stuck1");
    endtask

    task automatic test_saturate();
        run_stuck(2'd0, 8'd0, "sat_run");
        checks++;
        if (done2 !== 1'b1 || err_cnt2 !== 2'd3 || pass2 !== 1'b0) begin
            failures++;
            $display("FAIL saturate: done2=%b err2=%0d pass2=%b, required 1 3 0", done2, err_cnt2, pass2);
        end
        $display("saturate: err2=%0d", err_cnt2);
    endtask

    task automatic test_reset_mid();
        int j;
        pad_mode = 2'd2;
        pulse_start();
        repeat (11) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err_cnt !== 8'd1 || pif.io_t !== 1'b0 || pif.io_i !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: err=%0d io_t=%b io_i=%b busy=%b, required 1 0 1 1",
                     err_cnt, pif.io_t, pif.io_i, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (pif.io_t !== 1'b1 || pif.io_i !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: io_t=%b io_i=%b busy=%b err=%0d done=%b, required 1 0 0 0 0",
                     pif.io_t, pif.io_i, busy, err_cnt, done);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        $display("reset_mid: io_t=%b busy=%b err=%0d", pif.io_t, busy, err_cnt);
        pad_mode = 2'd0;
        pulse_start();
        @(negedge clk);
        wait_done(j);
        checks++;
        if (j != RUN_LEN || pass !== 1'b1 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL after_reset_run: done_at=%0d pass=%b err=%0d, required %0d 1 0", j, pass, err_cnt, RUN_LEN);
        end
        $display("after_reset_run: done_at=%0d pass=%b err=%0d", j, pass, err_cnt);
    endtask

    task automatic test_back_to_back();
        int j;
        pad_mode = 2'd1;
        pulse_start();
        @(negedge clk);
        j = 0;
        while (!done && j < 300) begin
            start = (j == 20 || j == 60);
            @(posedge clk); j++; @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (j != RUN_LEN || err_cnt !== 8'd4) begin
            failures++;
            $display("FAIL busy_start_ignored: done_at=%0d err=%0d, required %0d 4", j, err_cnt, RUN_LEN);
        end
        $display("busy_start_ignored: done_at=%0d err=%0d", j, err_cnt);
        pad_mode = 2'd0;
        pulse_start();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err_cnt !== 8'd0 || busy !== 1'b1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear: done=%b err=%0d busy=%b pass=%b, required 0 0 1 0", done, err_cnt, busy, pass);
        end
        wait_done(j);
        checks++;
        if (j != RUN_LEN || pass !== 1'b1 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL restart_run: done_at=%0d pass=%b err=%0d, required %0d 1 0", j, pass, err_cnt, RUN_LEN);
        end
        $display("restart_run: done_at=%0d pass=%b err=%0d", j, pass, err_cnt);
    endtask

`ifdef IOBUF_CHK_EXT_LOOP_EN
    task automatic test_ext_loop();
        ext_stuck0 = 1'b1;
        run_stuck(2'd0, 8'd4, "ext_stuck0");
        run_stuck(2'd1, 8'd8, "both_stuck0");
        ext_stuck0 = 1'b0;
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        pad_mode = 2'd0;
`ifdef IOBUF_CHK_EXT_LOOP_EN
        ext_stuck0 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        test_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        test_ideal();
        test_stuck();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
`ifdef IOBUF_CHK_EXT_LOOP_EN
        test_ext_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
